inst_loader: RTL and testbench

- Sits between the debugger's UART receive FIFO and the pipeline's instruction-memory write port.
- On a load command it pops raw bytes from the RX FIFO and assembles them little-endian into INST_SZ-bit instructions.
- For each completed instruction it drives a one-cycle write strobe with a sequential address.
- Loading ends on the halt instruction, on capacity overflow, or on an inter-byte timeout; the debugger reports the outcome.

---
 rtl/inst_loader_pkg.sv | 23 ++
 rtl/inst_loader_byte_assembler.sv | 49 ++++
 rtl/inst_loader.sv | 145 ++++++++++++++
 tb/tb_inst_loader.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// Shared definitions for the debugger/loader family: loader FSM encoding,
// completion codes and the default halt instruction.
package inst_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } load_state_t;

    localparam logic [1:0] LOAD_OK  = 2'd0;
    localparam logic [1:0] LOAD_OVF = 2'd1;
    localparam logic [1:0] LOAD_TMO = 2'd2;

    localparam logic [31:0] HALT_INST_DEFAULT = 32'hFFFF_FFFF;

    // Width of a counter indexing n items; never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/inst_loader_byte_assembler.sv
// Collects RX bytes little-endian into one instruction word; byte k lands in
// bits [k*UART_SZ +: UART_SZ] and the completed word is visible on the final pop.
module inst_loader_byte_assembler
    import inst_loader_pkg::*;
#(
    parameter int INST_SZ = 32,
    parameter int UART_SZ = 8,
    localparam int N_BYTES = INST_SZ / UART_SZ,
    localparam int IDX_W = idx_width(N_BYTES)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_push,
    input  logic [UART_SZ-1:0] i_byte,
    output logic [INST_SZ-1:0] o_word,
    output logic               o_word_complete,
    output logic [IDX_W-1:0]   o_byte_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

    logic [INST_SZ-1:0] shreg;
    logic [IDX_W-1:0]   byte_idx;

    // Merge the incoming byte combinationally so the owner can capture the
    // whole word on the same edge that pops its last byte.
    always_comb begin
        o_word = shreg;
        o_word[byte_idx*UART_SZ +: UART_SZ] = i_byte;
    end

    assign o_word_complete = i_push && (byte_idx == LAST_IDX);
    assign o_byte_idx      = byte_idx;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            shreg    <= '0;
            byte_idx <= '0;
        end else if (i_clear) begin
            shreg    <= '0;
            byte_idx <= '0;
        end else if (i_push) begin
            shreg    <= o_word;
            byte_idx <= o_word_complete ? '0 : byte_idx + 1'b1;
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Instruction loader: pops bytes from the debugger RX FIFO, assembles words and
// writes them to sequential instruction-memory addresses until halt/full/timeout.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int INST_SZ = 32,
    parameter int UART_SZ = 8,
    parameter int ADDR_W  = 8,
    parameter logic [INST_SZ-1:0] HALT_INST = INST_SZ'(HALT_INST_DEFAULT),
    parameter int TIMEOUT = 1_000_000
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [UART_SZ-1:0]  i_rx_data,
    input  logic                i_rx_empty,
    output logic                o_rx_rd,
    output logic [INST_SZ-1:0]  o_instruction,
    output logic [ADDR_W-1:0]   o_addr,
    output logic                o_write,
    output logic                o_busy,
    output logic                o_done,
    output logic [1:0]          o_error,
    output logic [ADDR_W:0]     o_count,
    output logic [1:0]          o_state
);

    localparam int N_BYTES = INST_SZ / UART_SZ;
    localparam int IDX_W   = idx_width(N_BYTES);
    localparam int TMO_W   = $clog2(TIMEOUT) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [ADDR_W:0]  FULL     = {1'b1, {ADDR_W{1'b0}}};

    load_state_t        state, state_next;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [INST_SZ-1:0] asm_word;
    logic               word_complete;
    logic [IDX_W-1:0]   byte_idx;
    logic               asm_clear;
    logic               tmo_hit;
    logic               is_halt;
    logic [ADDR_W:0]    count_next;

    // RX handshake: the FIFO head (i_rx_data) is valid whenever i_rx_empty=0;
    // o_rx_rd is our ready and a byte transfers on every edge where
    // o_rx_rd=1, which can only happen while the FIFO is non-empty.
    assign asm_clear = ((state == ST_IDLE) && i_start) || (state == ST_WRITE);

    inst_loader_byte_assembler #(
        .INST_SZ (INST_SZ),
        .UART_SZ (UART_SZ)
    ) u_asm (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_clear         (asm_clear),
        .i_push          (o_rx_rd),
        .i_byte          (i_rx_data),
        .o_word          (asm_word),
        .o_word_complete (word_complete),
        .o_byte_idx      (byte_idx)
    );

    // Timeout only guards gaps inside a word; waiting for a word's first byte is unbounded.
    assign tmo_hit    = (state == ST_RECV) && i_rx_empty && (byte_idx != '0)
                        && (tmo_cnt == TMO_LAST);
    assign is_halt    = (o_instruction == HALT_INST);
    assign count_next = o_count + 1'b1;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (i_start) state_next = ST_RECV;
            end
            ST_RECV: begin
                if (word_complete) state_next = ST_WRITE;
                else if (tmo_hit)  state_next = ST_DONE;
            end
            ST_WRITE: begin
                if (is_halt || (count_next == FULL)) state_next = ST_DONE;
                else                                 state_next = ST_RECV;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy  = (state != ST_IDLE);
        o_rx_rd = (state == ST_RECV) && !i_rx_empty;
        o_write = (state == ST_WRITE);
        o_done  = (state == ST_DONE);
        o_state = state;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_instruction <= '0;
            o_addr        <= '0;
            o_count       <= '0;
            o_error       <= LOAD_OK;
            tmo_cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        o_addr  <= '0;
                        o_count <= '0;
                        o_error <= LOAD_OK;
                        tmo_cnt <= '0;
                    end
                end
                ST_RECV: begin
                    if (o_rx_rd) begin
                        tmo_cnt <= '0;
                        if (word_complete) o_instruction <= asm_word;
                    end else if (byte_idx != '0) begin
                        if (tmo_hit) o_error <= LOAD_TMO;
                        else         tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_WRITE: begin
                    o_count <= count_next;
                    o_addr  <= o_addr + 1'b1;
                    tmo_cnt <= '0;
                    // A halt wins even when it fills the last slot.
                    if (is_halt)                    o_error <= LOAD_OK;
                    else if (count_next == FULL)    o_error <= LOAD_OVF;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Randomized scoreboard bench for inst_loader with a byte-stream reference model.
module tb_inst_loader;

  localparam int INST_SZ = 32;
  localparam int UART_SZ = 8;
  localparam int ADDR_W  = 2;
  localparam int TIMEOUT = 20;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic               i_clk;
  logic               i_reset;
  logic               i_start;
  logic [UART_SZ-1:0] i_rx_data;
  logic               i_rx_empty;
  logic               o_rx_rd;
  logic [INST_SZ-1:0] o_instruction;
  logic [ADDR_W-1:0]  o_addr;
  logic               o_write;
  logic               o_busy;
  logic               o_done;
  logic [1:0]         o_error;
  logic [ADDR_W:0]    o_count;
  logic [1:0]         o_state;

  inst_loader #(
    .INST_SZ (INST_SZ),
    .UART_SZ (UART_SZ),
    .ADDR_W  (ADDR_W),
    .HALT_INST (HALT),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_rx_data     (i_rx_data),
    .i_rx_empty    (i_rx_empty),
    .o_rx_rd       (o_rx_rd),
    .o_instruction (o_instruction),
    .o_addr        (o_addr),
    .o_write       (o_write),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_error       (o_error),
    .o_count       (o_count),
    .o_state       (o_state)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_pop_cyc = 0;
  int done_cnt = 0;
  int hold = 0;
  int exp_left = 0;
  bit throttle = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] stage_q[$];
  logic [ADDR_W+INST_SZ-1:0] exp_wr_q[$];
  logic [2+ADDR_W:0] exp_done_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic refresh_rx();
    i_rx_empty = (fifo_q.size() == 0) || (hold > 0);
    i_rx_data  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  endtask

  // RX FIFO model: pops on edges where the loader reads, optional gaps after each pop
  always @(posedge i_clk) begin
    cyc++;
    if (o_rx_rd) begin
      if (fifo_q.size() > 0) fifo_q.delete(0);
      last_pop_cyc = cyc;
      hold = throttle ? int'($urandom_range(0, 3)) : 0;
    end else if (hold > 0) begin
      hold--;
    end
    #1 refresh_rx();
  end

  // monitor / scoreboard
  always @(negedge i_clk) begin
    logic [ADDR_W+INST_SZ-1:0] ew;
    logic [2+ADDR_W:0] ed;
    if (i_reset) begin
      if (o_rx_rd) check("rx_rd_while_empty", 64'(i_rx_empty), 64'd0);
      if (o_write) begin
        if (exp_wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr=%0h inst=%0h expected none", o_addr, o_instruction);
        end else begin
          ew = exp_wr_q.pop_front();
          check("write_addr_inst", 64'({o_addr, o_instruction}), 64'(ew));
        end
      end
      if (o_done) begin
        if (exp_done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: err=%0d count=%0d expected none", o_error, o_count);
        end else begin
          ed = exp_done_q.pop_front();
          check("done_err_count", 64'({o_error, o_count}), 64'(ed));
          if (ed[2+ADDR_W -: 2] == 2'd2)
            check("timeout_latency", 64'(cyc - last_pop_cyc), 64'(TIMEOUT));
        end
        done_cnt++;
      end
    end
  end

  // reference model: chunk the byte stream into little-endian words and apply the stop rules
  task automatic model_load();
    int n = 0;
    int used = 0;
    bit term = 0;
    logic [31:0] w;
    for (int i = 0; i + 3 < int'(stage_q.size()) && !term; i += 4) begin
      w = {stage_q[i+3], stage_q[i+2], stage_q[i+1], stage_q[i]};
      exp_wr_q.push_back({ADDR_W'(n), w});
      n++;
      used += 4;
      if (w == HALT) begin
        exp_done_q.push_back({2'd0, (ADDR_W+1)'(n)});
        term = 1;
      end else if (n == (1 << ADDR_W)) begin
        exp_done_q.push_back({2'd1, (ADDR_W+1)'(n)});
        term = 1;
      end
    end
    if (!term && used < int'(stage_q.size())) begin
      exp_done_q.push_back({2'd2, (ADDR_W+1)'(n)});
      used = stage_q.size();
    end
    exp_left = int'(stage_q.size()) - used;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) stage_q.push_back(w[k*8 +: 8]);
  endtask

  task automatic pulse_start();
    @(negedge i_clk) i_start = 1'b1;
    @(negedge i_clk) i_start = 1'b0;
  endtask

  task automatic wait_done(input int start_cnt);
    bit seen = 0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge i_clk);
      if (done_cnt > start_cnt) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL wait_done: no o_done within 3000 cycles, expected one");
    end
  endtask

  task automatic finish_load();
    @(negedge i_clk);
    check("fifo_left", 64'(fifo_q.size()), 64'(exp_left));
    check("pending_writes", 64'(exp_wr_q.size()), 64'd0);
    fifo_q.delete();
    hold = 0;
    repeat (2) @(negedge i_clk);
  endtask

  task automatic run_load(input bit extra_start);
    int c0 = done_cnt;
    model_load();
    foreach (stage_q[i]) fifo_q.push_back(stage_q[i]);
    stage_q.delete();
    pulse_start();
    if (extra_start) pulse_start();
    wait_done(c0);
    finish_load();
  endtask

  initial begin
    int c0;
    i_reset = 1'b0;
    i_start = 1'b0;
    refresh_rx();
    repeat (3) @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);

    // reset state
    check("rst_busy", 64'(o_busy), 0);
    check("rst_write", 64'(o_write), 0);
    check("rst_done", 64'(o_done), 0);
    check("rst_rx_rd", 64'(o_rx_rd), 0);
    check("rst_inst", 64'(o_instruction), 0);
    check("rst_addr", 64'(o_addr), 0);
    check("rst_count", 64'(o_count), 0);
    check("rst_error", 64'(o_error), 0);

    // single word then halt
    stage_q = '{8'h78, 8'h56, 8'h34, 8'h12};
    push_word(HALT);
    run_load(0);

    // overflow: four non-halt words
    push_word(32'h1111_0001); push_word(32'h2222_0002);
    push_word(32'h3333_0003); push_word(32'h4444_0004);
    run_load(0);

    // halt as the last storable word is ok; surplus bytes stay in the FIFO
    push_word(32'hA); push_word(32'hB); push_word(32'hC); push_word(HALT);
    stage_q.push_back(8'h5A); stage_q.push_back(8'hA5);
    run_load(0);

    // timeout after two bytes
    stage_q = '{8'h01, 8'h02};
    run_load(0);

    // starved start: no timeout while waiting for the first byte
    c0 = done_cnt;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      repeat (25) @(negedge i_clk);
      check("starved_busy", 64'(o_busy), 64'd1);
    end
    push_word(HALT);
    model_load();
    foreach (stage_q[i]) fifo_q.push_back(stage_q[i]);
    stage_q.delete();
    wait_done(c0);
    finish_load();

    // reset in the middle of a word
    fifo_q = '{8'h11, 8'h22, 8'h33};
    pulse_start();
    for (int i = 0; i < 50 && fifo_q.size() != 0; i++) @(negedge i_clk);
    check("mid_word_bytes_taken", 64'(fifo_q.size()), 64'd0);
    @(posedge i_clk);
    #2 i_reset = 1'b0;
    #1;
    check("mid_rst_busy", 64'(o_busy), 0);
    check("mid_rst_inst", 64'(o_instruction), 0);
    check("mid_rst_state", 64'(o_state), 0);
    fifo_q.delete();
    hold = 0;
    refresh_rx();
    @(negedge i_clk) i_reset = 1'b1;
    push_word(32'h00C0_FFEE); push_word(HALT);
    run_load(0);

    // throttled FIFO
    throttle = 1;
    push_word(32'hDEAD_BEEF); push_word(32'h0BAD_F00D); push_word(HALT);
    run_load(0);

    // random loads
    for (int t = 0; t < 30; t++) begin
      int nw;
      int extra;
      bit term;
      logic [31:0] w;
      throttle = $urandom_range(0, 1);
      nw = $urandom_range(1, 5);
      term = (nw >= 4);
      for (int k = 0; k < nw; k++) begin
        w = ($urandom_range(0, 3) == 0) ? HALT : $urandom;
        if (w == HALT && k < 4) term = 1;
        push_word(w);
      end
      extra = $urandom_range(0, 3);
      for (int k = 0; k < extra; k++) stage_q.push_back(8'($urandom));
      if (!term && extra == 0) push_word(HALT);
      run_load(bit'($urandom_range(0, 1)));
    end

    check("all_done_consumed", 64'(exp_done_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
